// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin byte arbiter feeding a credit-tracked UART TX FIFO
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*8-1:0]          req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          tx_wr_o,
  output logic [7:0]                    tx_data_o,
  input  logic                          tx_pop_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [$clog2(FIFO_DEPTH):0]   credit_o,
  output logic                          credit_err_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  typedef enum logic {IDLE, LOCK} state_t;
  state_t        state;
  logic [IW-1:0] rr_ptr, gidx, win, cand;
  logic [BW-1:0] burst, burst_nxt;
  logic          found, hs, pop_eff, release_now;
  int            idx;
  assign req_ready_o = (state == LOCK && credit_o != '0) ? grant_o : '0;
  assign hs          = |(req_valid_i & req_ready_o);
  assign burst_nxt   = burst + 1'b1;
  assign release_now = hs && (req_last_i[gidx] || burst_nxt == BW'(MAX_BURST));
  assign pop_eff     = tx_pop_i && credit_o != CW'(FIFO_DEPTH);
  // first valid requester at or after rr_ptr, wrapping around
  always_comb begin
    win   = rr_ptr;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx  = (int'(rr_ptr) + i) % NUM_REQ;
      cand = IW'(idx);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end
  // grant/lock FSM, burst count, credit tracking and registered FIFO push
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      grant_o      <= '0;
      rr_ptr       <= '0;
      gidx         <= '0;
      burst        <= '0;
      tx_wr_o      <= 1'b0;
      tx_data_o    <= '0;
      credit_o     <= CW'(FIFO_DEPTH);
      credit_err_o <= 1'b0;
    end else begin
      tx_wr_o  <= hs;
      credit_o <= credit_o - CW'(hs) + CW'(pop_eff);
      if (hs) tx_data_o <= req_data_i[{gidx, 3'b000} +: 8];
      if (tx_pop_i && !pop_eff) credit_err_o <= 1'b1;
      if (state == IDLE) begin
        if (found) begin
          state   <= LOCK;
          grant_o <= NUM_REQ'(1) << win;
          gidx    <= win;
          burst   <= '0;
        end
      end else if (hs) begin
        burst <= burst_nxt;
        if (release_now) begin
          state   <= IDLE;
          grant_o <= '0;
          rr_ptr  <= (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
        end
      end
    end
  end
endmodule
